// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers
// for the VGA timing generator.
package vga_timing_pkg;

  localparam int COUNT_W = 11;
  localparam int MAX_TOTAL = 2048;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BACK = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BACK = 33;

  function automatic int axis_total(
    input int act,
    input int front,
    input int sync,
    input int back
  );
    return act + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter
// plus active / sync region flags.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FRONT = DEF_H_FRONT,
  parameter int SYNC = DEF_H_SYNC,
  parameter int BACK = DEF_H_BACK
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COUNT_W-1:0] count,
  output logic               active,
  output logic               in_sync,
  output logic               wrap
);

  localparam int TOTAL = axis_total(ACTIVE, FRONT, SYNC, BACK);
  localparam logic [COUNT_W-1:0] LAST = COUNT_W'(TOTAL - 1);
  localparam logic [COUNT_W-1:0] ACT_END = COUNT_W'(ACTIVE);
  localparam logic [COUNT_W-1:0] SYN_BEG = COUNT_W'(ACTIVE + FRONT);
  localparam logic [COUNT_W-1:0] SYN_END = COUNT_W'(ACTIVE + FRONT + SYNC);

  logic [COUNT_W-1:0] count_q, count_d;

  // Next position: step when advancing, wrap at the last position
  always_comb begin
    count_d = count_q;
    if (advance) begin
      count_d = wrap ? '0 : count_q + 1'b1;
    end
  end

  // Position register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count   = count_q;
  assign wrap    = (count_q == LAST);
  assign active  = (count_q < ACT_END);
  assign in_sync = (count_q >= SYN_BEG) && (count_q < SYN_END);

endmodule

// File: rtl/vga_timing_generator.sv
// Raster timing: counters, syncs, blanking, frame
// start and one-cycle-early pixel request, all registered.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BACK = DEF_H_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BACK = DEF_V_BACK,
  parameter bit H_POL = 1'b0,
  parameter bit V_POL = 1'b0
) (
  input  logic               pixel_clock,
  input  logic               reset_n,
  input  logic               enable,
  output logic               h_synch,
  output logic               v_synch,
  output logic               comp_synch,
  output logic               blank,
  output logic [COUNT_W-1:0] pixel_count,
  output logic [COUNT_W-1:0] line_count,
  output logic               frame_start,
  output logic               pixel_req
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
  localparam logic [COUNT_W-1:0] H_ACT_END = COUNT_W'(H_ACTIVE);
  localparam logic [COUNT_W-1:0] V_ACT_END = COUNT_W'(V_ACTIVE);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $error("vga_timing_generator: H_TOTAL/V_TOTAL exceed 2048");
  end

  logic [COUNT_W-1:0] h_count, v_count;
  logic [COUNT_W-1:0] h_next, v_next;
  logic h_active, h_in_sync, h_wrap;
  logic v_active, v_in_sync, v_wrap;
  logic v_advance;

  // Lines step only on an enabled horizontal wrap
  assign v_advance = h_wrap && enable;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FRONT(H_FRONT),
    .SYNC(H_SYNC), .BACK(H_BACK)
  ) u_h_axis (
    .clk(pixel_clock), .rst_n(reset_n),
    .advance(enable), .count(h_count),
    .active(h_active), .in_sync(h_in_sync),
    .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FRONT(V_FRONT),
    .SYNC(V_SYNC), .BACK(V_BACK)
  ) u_v_axis (
    .clk(pixel_clock), .rst_n(reset_n),
    .advance(v_advance), .count(v_count),
    .active(v_active), .in_sync(v_in_sync),
    .wrap(v_wrap)
  );

  logic h_synch_q, h_synch_d;
  logic v_synch_q, v_synch_d;
  logic comp_synch_q, comp_synch_d;
  logic blank_q, blank_d;
  logic [COUNT_W-1:0] pixel_count_q, pixel_count_d;
  logic [COUNT_W-1:0] line_count_q, line_count_d;
  logic frame_start_q, frame_start_d;
  logic pixel_req_q, pixel_req_d;

  // Output values for the current position; syncs hold while disabled
  always_comb begin
    h_next = h_wrap ? '0 : h_count + 1'b1;
    v_next = v_count;
    if (h_wrap) v_next = v_wrap ? '0 : v_count + 1'b1;
    h_synch_d     = h_synch_q;
    v_synch_d     = v_synch_q;
    comp_synch_d  = comp_synch_q;
    if (enable) begin
      h_synch_d    = h_in_sync ? H_POL : !H_POL;
      v_synch_d    = v_in_sync ? V_POL : !V_POL;
      comp_synch_d = !(h_in_sync || v_in_sync);
    end
    blank_d       = !(h_active && v_active) || !enable;
    pixel_count_d = h_count;
    line_count_d  = v_count;
    frame_start_d = enable && (h_count == '0) && (v_count == '0);
    pixel_req_d   = enable && (h_next < H_ACT_END) &&
                    (v_next < V_ACT_END);
  end

  // Output register stage
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      h_synch_q     <= !H_POL;
      v_synch_q     <= !V_POL;
      comp_synch_q  <= 1'b1;
      blank_q       <= 1'b1;
      pixel_count_q <= '0;
      line_count_q  <= '0;
      frame_start_q <= 1'b0;
      pixel_req_q   <= 1'b0;
    end else begin
      h_synch_q     <= h_synch_d;
      v_synch_q     <= v_synch_d;
      comp_synch_q  <= comp_synch_d;
      blank_q       <= blank_d;
      pixel_count_q <= pixel_count_d;
      line_count_q  <= line_count_d;
      frame_start_q <= frame_start_d;
      pixel_req_q   <= pixel_req_d;
    end
  end

  assign h_synch     = h_synch_q;
  assign v_synch     = v_synch_q;
  assign comp_synch  = comp_synch_q;
  assign blank       = blank_q;
  assign pixel_count = pixel_count_q;
  assign line_count  = line_count_q;
  assign frame_start = frame_start_q;
  assign pixel_req   = pixel_req_q;

endmodule

// File: tb/tb_vga_timing_generator.sv
// Scoreboard bench: default-timing instance plus a
// small active-high-sync instance sharing one clock.
module tb_vga_timing_generator;

  typedef struct packed {
    logic hs, vs, cs, bl;
    logic [10:0] pc, lc;
    logic fs, pr;
  } vo_t;

  localparam int HA_A = 640, HF_A = 16, HS_A = 96, HB_A = 48;
  localparam int VA_A = 480, VF_A = 10, VS_A = 2, VB_A = 33;
  localparam int HT_A = 800, VT_A = 525;
  localparam int HA_B = 8, HF_B = 2, HS_B = 3, HB_B = 3;
  localparam int VA_B = 6, VF_B = 1, VS_B = 2, VB_B = 1;
  localparam int HT_B = 16, VT_B = 10;

  localparam vo_t RST_A = '{hs:1'b1, vs:1'b1, cs:1'b1, bl:1'b1,
                            pc:'0, lc:'0, fs:1'b0, pr:1'b0};
  localparam vo_t RST_B = '{hs:1'b0, vs:1'b0, cs:1'b1, bl:1'b1,
                            pc:'0, lc:'0, fs:1'b0, pr:1'b0};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en_a = 1'b1;
  logic en_b = 1'b1;

  logic hs_a, vs_a, cs_a, bl_a, fs_a, pr_a;
  logic [10:0] pc_a, lc_a;
  logic hs_b, vs_b, cs_b, bl_b, fs_b, pr_b;
  logic [10:0] pc_b, lc_b;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_timing_generator u_dut_a (
    .pixel_clock(clk), .reset_n(rst_n), .enable(en_a),
    .h_synch(hs_a), .v_synch(vs_a), .comp_synch(cs_a),
    .blank(bl_a), .pixel_count(pc_a), .line_count(lc_a),
    .frame_start(fs_a), .pixel_req(pr_a)
  );

  vga_timing_generator #(
    .H_ACTIVE(HA_B), .H_FRONT(HF_B), .H_SYNC(HS_B), .H_BACK(HB_B),
    .V_ACTIVE(VA_B), .V_FRONT(VF_B), .V_SYNC(VS_B), .V_BACK(VB_B),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_dut_b (
    .pixel_clock(clk), .reset_n(rst_n), .enable(en_b),
    .h_synch(hs_b), .v_synch(vs_b), .comp_synch(cs_b),
    .blank(bl_b), .pixel_count(pc_b), .line_count(lc_b),
    .frame_start(fs_b), .pixel_req(pr_b)
  );

  wire vo_t obs_a = '{hs:hs_a, vs:vs_a, cs:cs_a, bl:bl_a,
                      pc:pc_a, lc:lc_a, fs:fs_a, pr:pr_a};
  wire vo_t obs_b = '{hs:hs_b, vs:vs_b, cs:cs_b, bl:bl_b,
                      pc:pc_b, lc:lc_b, fs:fs_b, pr:pr_b};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, obs, exp_v, $time);
    end
  endtask

  // Behavioural reference for one output cycle at position (h,v)
  function automatic vo_t model_out(
    input int h, input int v, input bit en, input vo_t prev,
    input int ha, input int hf, input int hs, input int hb,
    input int va, input int vf, input int vs, input int vb,
    input bit hp, input bit vp
  );
    vo_t e;
    int ht, vt, nh, nv;
    bit hsy, vsy;
    ht  = ha + hf + hs + hb;
    vt  = va + vf + vs + vb;
    nh  = (h + 1) % ht;
    nv  = (h == ht - 1) ? (v + 1) % vt : v;
    hsy = (h >= ha + hf) && (h < ha + hf + hs);
    vsy = (v >= va + vf) && (v < va + vf + vs);
    e = prev;
    if (en) begin
      e.hs = hsy ? hp : !hp;
      e.vs = vsy ? vp : !vp;
      e.cs = !(hsy || vsy);
    end
    e.bl = !((h < ha) && (v < va)) || !en;
    e.pc = 11'(h);
    e.lc = 11'(v);
    e.fs = en && (h == 0) && (v == 0);
    e.pr = en && (nh < ha) && (nv < va);
    return e;
  endfunction

  vo_t q_a[$];
  vo_t q_b[$];
  int h_a = 0, v_a = 0, h_b = 0, v_b = 0;
  vo_t prev_a = RST_A;
  vo_t prev_b = RST_B;

  // Reference model: push the expected outputs for each edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_a = 0; v_a = 0; prev_a = RST_A; q_a.delete();
      h_b = 0; v_b = 0; prev_b = RST_B; q_b.delete();
    end else begin
      prev_a = model_out(h_a, v_a, en_a, prev_a, HA_A, HF_A, HS_A,
                         HB_A, VA_A, VF_A, VS_A, VB_A, 1'b0, 1'b0);
      q_a.push_back(prev_a);
      if (en_a) begin
        if (h_a == HT_A - 1) begin
          h_a = 0;
          v_a = (v_a == VT_A - 1) ? 0 : v_a + 1;
        end else h_a++;
      end
      prev_b = model_out(h_b, v_b, en_b, prev_b, HA_B, HF_B, HS_B,
                         HB_B, VA_B, VF_B, VS_B, VB_B, 1'b1, 1'b1);
      q_b.push_back(prev_b);
      if (en_b) begin
        if (h_b == HT_B - 1) begin
          h_b = 0;
          v_b = (v_b == VT_B - 1) ? 0 : v_b + 1;
        end else h_b++;
      end
    end
  end

  // Scoreboard compare just after each active edge
  always @(posedge clk) begin
    #1;
    if (q_a.size() > 0) chk("sb_a", 32'(obs_a), 32'(q_a.pop_front()));
    else if (!rst_n)    chk("rst_a", 32'(obs_a), 32'(RST_A));
    else                chk("sb_a_underflow", 32'(q_a.size()), 32'd1);
    if (q_b.size() > 0) chk("sb_b", 32'(obs_b), 32'(q_b.pop_front()));
    else if (!rst_n)    chk("rst_b", 32'(obs_b), 32'(RST_B));
    else                chk("sb_b_underflow", 32'(q_b.size()), 32'd1);
  end

  task automatic wait_a(input int h, input int v);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(pc_a == 11'(h) && lc_a == 11'(v)) && n < 3000);
    chk("reach_a", {10'd0, pc_a, lc_a}, {10'd0, 11'(h), 11'(v)});
  endtask

  task automatic wait_b(input int h, input int v);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!(pc_b == 11'(h) && lc_b == 11'(v)) && n < 400);
    chk("reach_b", {10'd0, pc_b, lc_b}, {10'd0, 11'(h), 11'(v)});
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_a", 32'(obs_a), 32'(RST_A));
    chk("reset_b", 32'(obs_b), 32'(RST_B));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_a", {pc_a, lc_a, fs_a, bl_a}, {11'd0, 11'd0, 1'b1, 1'b0});
    chk("first_b", {pc_b, lc_b, fs_b, bl_b}, {11'd0, 11'd0, 1'b1, 1'b0});

    // Line scan on the default timing
    wait_a(638, 0);
    chk("preq_638", 32'(pr_a), 32'd1);
    @(posedge clk); #1;
    chk("preq_639", 32'(pr_a), 32'd0);
    chk("blank_639", 32'(bl_a), 32'd0);
    @(posedge clk); #1;
    chk("blank_640", 32'(bl_a), 32'd1);
    wait_a(655, 0);
    chk("hs_655", {hs_a, cs_a}, 2'b11);
    @(posedge clk); #1;
    chk("hs_656", {hs_a, cs_a}, 2'b00);
    wait_a(751, 0);
    chk("hs_751", {hs_a, cs_a}, 2'b00);
    @(posedge clk); #1;
    chk("hs_752", {hs_a, cs_a}, 2'b11);
    wait_a(799, 0);
    chk("preq_799", 32'(pr_a), 32'd1);

    // Enable gap with the counter sitting at (700,1)
    wait_a(699, 1);
    @(negedge clk) en_a = 1'b0;
    @(posedge clk); #1;
    chk("hold_pos", {pc_a, lc_a}, {11'd700, 11'd1});
    chk("hold_flags", {bl_a, pr_a, fs_a}, 3'b100);
    repeat (48) @(posedge clk);
    #1;
    chk("hold_pos_end", {pc_a, lc_a}, {11'd700, 11'd1});
    @(negedge clk) en_a = 1'b1;
    @(posedge clk); #1;
    chk("resume_700", {pc_a, lc_a}, {11'd700, 11'd1});
    @(posedge clk); #1;
    chk("resume_701", {pc_a, lc_a}, {11'd701, 11'd1});

    // Small frame, active-high syncs
    wait_b(10, 1);
    chk("hs_b_on", {hs_b, cs_b}, 2'b10);
    wait_b(15, 6);
    chk("vs_b_pre", {vs_b, bl_b}, 2'b01);
    @(posedge clk); #1;
    chk("vs_b_on", {vs_b, cs_b, lc_b}, {1'b1, 1'b0, 11'd7});
    wait_b(15, 8);
    chk("vs_b_last", 32'(vs_b), 32'd1);
    @(posedge clk); #1;
    chk("vs_b_off", {vs_b, cs_b, lc_b}, {1'b0, 1'b1, 11'd9});
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!fs_b && n < 400);
    chk("fs_b_seen", 32'(fs_b), 32'd1);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!fs_b && n < 400);
    chk("fs_b_period", n, HT_B * VT_B);

    // Asynchronous reset mid-line
    wait_a(320, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_a", 32'(obs_a), 32'(RST_A));
    chk("async_rst_b", 32'(obs_b), 32'(RST_B));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("restart_a", {pc_a, lc_a, fs_a}, {11'd0, 11'd0, 1'b1});
    repeat (400) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
